// File: rtl/wb_sram_pkg.sv
// wb_sram_pkg: shared SRAM geometry, controller states and byte-lane helper
package wb_sram_pkg;
    localparam int SRAM_ADDR_WIDTH = 18;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int SRAM_LANES = SRAM_DATA_WIDTH / 8;
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    function automatic logic [SRAM_DATA_WIDTH-1:0] lane_mask(input logic [SRAM_LANES-1:0] sel);
        for (int i = 0; i < SRAM_LANES; i++) lane_mask[i*8 +: 8] = {8{sel[i]}};
    endfunction
endpackage

// File: rtl/wb_sram.sv
// wb_sram: Wishbone classic slave turning one request into a timed asynchronous SRAM access
module wb_sram
    import wb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH  = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = SRAM_DATA_WIDTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [SRAM_LANES-1:0] wb_sel_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic [ADDR_WIDTH-1:0] sram_a_o,
    inout  wire  [DATA_WIDTH-1:0] sram_d_io,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o,
    output logic                  sram_lb_n_o,
    output logic                  sram_ub_n_o
);
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic we_q, we_d, drive_q, ack_d, busy_d;
    logic [SRAM_LANES-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d, rdat_d;
    logic [ADDR_WIDTH-1:0] adr_d;

    assign sram_d_io = drive_q ? dat_q : 'z;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        we_d = we_q;
        sel_d = sel_q;
        dat_d = dat_q;
        adr_d = sram_a_o;
        rdat_d = wb_dat_o;
        ack_d = 1'b0;
        case (state_q)
            IDLE: if (wb_cyc_i && wb_stb_i) begin
                state_d = ACCESS;
                cnt_d = 4'(WAIT_STATES);
                we_d = wb_we_i;
                sel_d = wb_sel_i;
                dat_d = wb_dat_i;
                adr_d = wb_adr_i;
            end
            ACCESS: if (!wb_cyc_i) state_d = IDLE;
                else if (cnt_q == '0) begin
                    state_d = ACK;
                    ack_d = 1'b1;
                    rdat_d = we_q ? wb_dat_o : sram_d_io & lane_mask(sel_q);
                end else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q <= '0;
            we_q <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
            drive_q <= 1'b0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            sram_a_o <= '0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
            sram_lb_n_o <= 1'b1;
            sram_ub_n_o <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            we_q <= we_d;
            sel_q <= sel_d;
            dat_q <= dat_d;
            wb_dat_o <= rdat_d;
            wb_ack_o <= ack_d;
            sram_a_o <= adr_d;
            sram_ce_n_o <= !busy_d;
            sram_oe_n_o <= !(state_d == ACCESS && !we_d);
            sram_we_n_o <= !(state_d == ACCESS && we_d);
            sram_lb_n_o <= !(busy_d && sel_d[0]);
            sram_ub_n_o <= !(busy_d && sel_d[1]);
            drive_q <= busy_d && we_d;
        end
    end
endmodule

// File: doc/wb_sram.md
Name: wb_sram

Overview:
Wishbone classic slave that maps the J1 CPU data bus onto the board's asynchronous 256K x 16 SRAM (SRAM_A/D/CE_n/OE_n/WE_n/LB_n/UB_n pins of top_c5gx). It sits directly downstream of the CPU's Wishbone interconnect, beside wb_rom and the GPIO slave. It converts one Wishbone request into a timed SRAM read or write with configurable wait states, byte-lane control and a registered ack.

Parameters:
ADDR_WIDTH, 18, word address width (SRAM_A)
DATA_WIDTH, 16, data width (SRAM_D); byte lanes = DATA_WIDTH/8 = 2
WAIT_STATES, 1, extra ACCESS cycles beyond the first (0..15)

Ports:
clk_i  in  1  system clock (50 MHz, CLOCK_50_B5B domain)
rst_ni  in  1  asynchronous active-low reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  1 = write
wb_adr_i  in  ADDR_WIDTH  word address
wb_sel_i  in  2  byte selects; [0] = D[7:0], [1] = D[15:8]
wb_dat_i  in  DATA_WIDTH  write data
wb_dat_o  out  DATA_WIDTH  read data, registered
wb_ack_o  out  1  single-cycle acknowledge, registered
sram_a_o  out  ADDR_WIDTH  SRAM address
sram_d_io  inout  DATA_WIDTH  SRAM data, tristated when not writing
sram_ce_n_o  out  1  chip enable
sram_oe_n_o  out  1  output enable
sram_we_n_o  out  1  write enable
sram_lb_n_o  out  1  lower byte enable
sram_ub_n_o  out  1  upper byte enable

Behaviour:
- Reset (async, rst_ni low): state IDLE; wb_ack_o=0; wb_dat_o=0; sram_a_o=0; all sram_*_n_o=1; sram_d_io released (Z). Applies immediately, including mid-access.
- All SRAM control outputs come straight from flops (no combinational strobes).
- States: IDLE, ACCESS, ACK.
- IDLE: if wb_cyc_i & wb_stb_i: latch adr/we/sel/dat_i, load counter=WAIT_STATES, go ACCESS. Otherwise all strobes high, data Z.
- ACCESS: ce_n=0, a=latched address, lb_n=~sel[0], ub_n=~sel[1].
  - Read: oe_n=0, we_n=1, data Z.
  - Write: oe_n=1, we_n=0, sram_d_io driven with the latched data.
  - Counter decrements each cycle. At counter==0: read captures sram_d_io into wb_dat_o (unselected lanes forced to 0); set wb_ack_o; go ACK. Wait-state counter is 4 bits.
- ACK: wb_ack_o=1 for exactly this cycle. Write: we_n=1, ce_n=0, data still driven (hold time). Read: oe_n=1, ce_n=0. Next state IDLE unconditionally.
- Latency: stb sampled in cycle 0 -> ack high in cycle WAIT_STATES+2. ACCESS lasts WAIT_STATES+1 cycles.
- Back-to-back: stb held through ACK is re-sampled in IDLE. This gives at least one IDLE cycle with ce_n=1 and data Z between accesses (bus turnaround). Throughput is one access per WAIT_STATES+3 cycles.
- wb_dat_o holds its value until the next completed read. Writes do not alter it.
- sel=00: full cycle runs with lb_n=ub_n=1 (no array effect) and ack is still returned. A read returns 0.
- Abort: wb_cyc_i low during ACCESS -> next state IDLE, no ack, strobes high, data Z on the next edge. The content of an aborted write's target word is undefined.
- wb_cyc_i low during ACK: ack still completes (it is already registered).
- Input changes during ACCESS/ACK are ignored; only the latched request is used.

Decomposition:
- Package wb_sram_pkg: state enum (IDLE, ACCESS, ACK), SRAM_ADDR_WIDTH=18, SRAM_DATA_WIDTH=16, SRAM_LANES=2.
- No RTL sub-module. Tristate handled by a single continuous assignment from a registered drive-enable.
- The bench uses a behavioural sram_model (bench-only): 10 ns access time; asserts on OE_n and WE_n low together.

Test Plan:
- WAIT_STATES=1, write 0xBEEF @0x12345 sel=11 -> we_n low cycles 1-2, ack cycle 3. Read back -> ack cycle 3, wb_dat_o=0xBEEF.
- Write 0x00AA @0x12345 sel=01, then read sel=11 -> 0xBEAA. Read sel=10 -> 0xBE00, lb_n=1 during ACCESS.
- Abort: drop wb_cyc_i in cycle 1 of a write -> no ack, we_n=1 and sram_d_io=Z from cycle 2, state IDLE.
- Back-to-back reads @0x00000 and @0x3FFFF, stb held -> acks in cycles 3 and 7, ce_n=1 and data Z in cycle 4.
- Reset pulse mid-write (cycle 2) -> all sram_*_n_o=1, ack=0, data Z in the same time step, no ack after release.
- WAIT_STATES=0 and 15: write/read 0x5A5A -> ack at cycle 2 and 17 respectively, data matches.
